tag_match_cam: RTL and testbench
================================

TAG_MATCH_CAM -- requirements
Module: tag_match_cam

Interface
REQ-001 The block SHALL have parameter TAG_W, 10, tag width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, 8, number of entries (power of two, >=2).
REQ-003 The block SHALL have localparam IDX_W, $clog2(DEPTH), entry index width.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port wr_en  input  1  write the tag into an entry and set that entry valid.
REQ-007 Port wr_idx  input  IDX_W  entry written.
REQ-008 Port wr_tag  input  TAG_W  tag written.
REQ-009 Port inv_en  input  1  clear one entry's valid bit.
REQ-010 Port inv_idx  input  IDX_W  entry invalidated.
REQ-011 Port flush  input  1  clear all valid bits.
REQ-012 Port srch_en  input  1  search request.
REQ-013 Port srch_tag  input  TAG_W  tag searched.
REQ-014 Port res_valid  output  1  search result valid this cycle.
REQ-015 Port res_hit  output  1  at least one valid entry matched.
REQ-016 Port res_idx  output  IDX_W  lowest matching index, 0 on miss.
REQ-017 Port res_vec  output  DEPTH  per-entry match vector.
REQ-018 Port res_multi  output  1  more than one entry matched.
REQ-019 Port occupancy  output  IDX_W+1  count of valid entries.

Function
REQ-020 Entry i SHALL match when valid[i]=1 and tag[i] equals srch_tag on all TAG_W bits.
REQ-021 Search SHALL have 1-cycle latency: srch_en in cycle N -> res_* registered and res_valid=1 in cycle N+1.
REQ-022 res_valid SHALL be 0 in any cycle following one with srch_en=0; res_hit/res_idx/res_vec/res_multi SHALL then be 0.
REQ-023 A search SHALL see entry state before that cycle's write/invalidate/flush (read-before-write).
REQ-024 Write and invalidate to the same index in one cycle: write SHALL win (entry valid, new tag).
REQ-025 flush SHALL override wr_en and inv_en in the same cycle: all entries invalid afterwards, no write performed.
REQ-026 Writing an already-valid entry SHALL overwrite its tag, occupancy unchanged.
REQ-027 Invalidating an already-invalid entry SHALL be a no-op.
REQ-028 occupancy SHALL reflect valid bits after the edge; range 0..DEPTH, no wrap.
REQ-029 res_idx SHALL use fixed priority, lowest index wins; res_multi=1 iff popcount(res_vec)>1.
REQ-030 Duplicate tags in multiple entries SHALL be allowed; no write-side uniqueness check.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear all valid bits, res_* outputs and occupancy to 0.
REQ-032 Tag storage SHALL NOT require reset; invalid entries never match regardless of contents.
REQ-033 Reset asserted during a search SHALL force res_valid=0 immediately; the pending search is dropped.
REQ-034 First search accepted SHALL be in the cycle rst_n is sampled high.

Structure
REQ-035 A shared package tag_pkg SHALL hold TAG_W default, DEPTH default and the tag_t typedef.
REQ-036 One sub-module, eq_compare #(W), SHALL implement W-bit equality (eq, neq outputs); DEPTH instances.
REQ-037 Priority encoder and popcount SHALL be inside tag_match_cam, no extra sub-modules.

Verification
REQ-038 Reset, write idx3 tag 0x155, search 0x155 -> next cycle res_valid=1, res_hit=1, res_idx=3, res_vec=8'b0000_1000, occupancy=1.
REQ-039 Write idx1 and idx5 tag 0x2AA, search 0x2AA -> res_idx=1, res_multi=1, res_vec=8'b0010_0010.
REQ-040 Same cycle: write idx2 tag 0x0F0 and search 0x0F0 -> res_hit=0; repeat search next cycle -> res_hit=1, res_idx=2.
REQ-041 Fill all 8 entries, occupancy=8; assert flush with wr_en idx0 -> occupancy=0, any search -> res_hit=0.
REQ-042 wr_en and inv_en both idx4 tag 0x3FF -> entry 4 valid, search 0x3FF hits idx4; inv_en alone idx4 -> miss.
REQ-043 Search issued, rst_n pulsed low mid-cycle -> res_valid=0 immediately, occupancy=0, post-reset search of prior tag misses.

Source files
------------

// File: rtl/tag_pkg.sv
// Shared defaults and the tag type for the tag-match CAM.
package tag_pkg;

  localparam int unsigned TAG_W_DEF = 10;
  localparam int unsigned DEPTH_DEF = 8;

  typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/tag_match_cam_eq_compare.sv
// W-bit equality comparator, one per CAM entry.
module eq_compare #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         neq
);

  // Full-width compare, with both polarities brought out.
  always_comb begin
    eq  = (a == b);
    neq = ~eq;
  end

endmodule

// File: rtl/tag_match_cam.sv
// Small fully associative tag CAM: per-entry valid/tag storage, a
// one-cycle registered search with lowest-index priority, and a running
// occupancy count.
module tag_match_cam
  import tag_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_idx,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic                      inv_en,
  input  logic [$clog2(DEPTH)-1:0]  inv_idx,
  input  logic                      flush,
  input  logic                      srch_en,
  input  logic [TAG_W-1:0]          srch_tag,
  output logic                      res_valid,
  output logic                      res_hit,
  output logic [$clog2(DEPTH)-1:0]  res_idx,
  output logic [DEPTH-1:0]          res_vec,
  output logic                      res_multi,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [IDX_W:0] popcnt(input logic [DEPTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [DEPTH-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [IDX_W:0]   r_occ;

  logic             r_res_valid;
  logic             r_res_hit;
  logic [IDX_W-1:0] r_res_idx;
  logic [DEPTH-1:0] r_res_vec;
  logic             r_res_multi;

  logic [DEPTH-1:0] w_valid_nxt;
  logic [DEPTH-1:0] w_eq;
  logic [DEPTH-1:0] w_neq;
  logic [DEPTH-1:0] w_match;
  logic [IDX_W-1:0] w_first;
  logic [IDX_W:0]   w_match_cnt;
  logic             w_multi;

  // Next valid vector: flush dominates; write is applied after invalidate so
  // it wins when both target the same entry.
  always_comb begin
    w_valid_nxt = r_valid;
    if (flush) begin
      w_valid_nxt = '0;
    end else begin
      if (inv_en) w_valid_nxt[inv_idx] = 1'b0;
      if (wr_en)  w_valid_nxt[wr_idx]  = 1'b1;
    end
  end

  // Valid bits and occupancy; the count tracks the post-edge valid vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= popcnt(w_valid_nxt);
    end
  end

  // Tag storage, unreset: an invalid entry can never match.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) r_tag[wr_idx] <= wr_tag;
  end

  // One comparator per entry against the current (pre-write) tags.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    eq_compare #(.W(TAG_W)) u_eq (
      .a   (r_tag[g]),
      .b   (srch_tag),
      .eq  (w_eq[g]),
      .neq (w_neq[g])
    );
  end

  // Lane match needs the entry valid and the compare rails to agree.
  always_comb begin
    w_match = r_valid & w_eq & ~w_neq;
  end

  // Fixed-priority encoder: scan high to low so the lowest index is last written.
  always_comb begin
    w_first = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_match[DEPTH-1-i]) w_first = IDX_W'(DEPTH-1-i);
    end
  end

  // Multi-hit detection from the match popcount.
  always_comb begin
    w_match_cnt = popcnt(w_match);
    w_multi     = (w_match_cnt > {{IDX_W{1'b0}}, 1'b1});
  end

  // Registered search result; all fields zero when no search was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_idx   <= '0;
      r_res_vec   <= '0;
      r_res_multi <= 1'b0;
    end else begin
      r_res_valid <= srch_en;
      r_res_hit   <= srch_en & (|w_match);
      r_res_idx   <= srch_en ? w_first : '0;
      r_res_vec   <= srch_en ? w_match : '0;
      r_res_multi <= srch_en & w_multi;
    end
  end

  assign res_valid = r_res_valid;
  assign res_hit   = r_res_hit;
  assign res_idx   = r_res_idx;
  assign res_vec   = r_res_vec;
  assign res_multi = r_res_multi;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_tag_match_cam.sv
// Directed bench for tag_match_cam with hand-computed expectations.
module tb_tag_match_cam;

  localparam int unsigned TAG_W = 10;
  localparam int unsigned DEPTH = 8;
  localparam int IDX_W = $clog2(DEPTH);

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             inv_en;
  logic [IDX_W-1:0] inv_idx;
  logic             flush;
  logic             srch_en;
  logic [TAG_W-1:0] srch_tag;
  logic             res_valid;
  logic             res_hit;
  logic [IDX_W-1:0] res_idx;
  logic [DEPTH-1:0] res_vec;
  logic             res_multi;
  logic [IDX_W:0]   occupancy;

  int unsigned n_vec;
  int unsigned n_miss;

  tag_match_cam #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .inv_en    (inv_en),
    .inv_idx   (inv_idx),
    .flush     (flush),
    .srch_en   (srch_en),
    .srch_tag  (srch_tag),
    .res_valid (res_valid),
    .res_hit   (res_hit),
    .res_idx   (res_idx),
    .res_vec   (res_vec),
    .res_multi (res_multi),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic h,
                         input logic [IDX_W-1:0] idx, input logic [DEPTH-1:0] vec,
                         input logic m);
    chk({tag, ".valid"}, 32'(res_valid), 32'(v));
    chk({tag, ".hit"},   32'(res_hit),   32'(h));
    chk({tag, ".idx"},   32'(res_idx),   32'(idx));
    chk({tag, ".vec"},   32'(res_vec),   32'(vec));
    chk({tag, ".multi"}, 32'(res_multi), 32'(m));
  endtask

  task automatic idle();
    wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0; srch_en = 1'b0;
  endtask

  initial begin
    int unsigned exp_occ [8];
    exp_occ = '{5, 5, 5, 5, 6, 6, 7, 8};
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    wr_idx = '0; wr_tag = '0; inv_idx = '0; srch_tag = '0;
    idle();
    #1;
    chk("rst.occ", 32'(occupancy), 32'd0);
    chk_res("rst", 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then search
    wr_en = 1'b1; wr_idx = 3'd3; wr_tag = 10'h155;
    tick();
    idle(); srch_en = 1'b1; srch_tag = 10'h155;
    tick();
    chk_res("w3", 1'b1, 1'b1, 3'd3, 8'b0000_1000, 1'b0);
    chk("w3.occ", 32'(occupancy), 32'd1);
    idle();
    tick();
    chk_res("idle", 1'b0, 1'b0, '0, '0, 1'b0);

    // Duplicate tags, multi-hit, lowest index wins
    wr_en = 1'b1; wr_idx = 3'd1; wr_tag = 10'h2AA;
    tick();
    wr_idx = 3'd5;
    tick();
    idle(); srch_en = 1'b1; srch_tag = 10'h2AA;
    tick();
    chk_res("dup", 1'b1, 1'b1, 3'd1, 8'b0010_0010, 1'b1);
    chk("dup.occ", 32'(occupancy), 32'd3);

    // Read-before-write
    wr_en = 1'b1; wr_idx = 3'd2; wr_tag = 10'h0F0; srch_en = 1'b1; srch_tag = 10'h0F0;
    tick();
    chk_res("rbw0", 1'b1, 1'b0, '0, '0, 1'b0);
    chk("rbw0.occ", 32'(occupancy), 32'd4);
    wr_en = 1'b0;
    tick();
    chk_res("rbw1", 1'b1, 1'b1, 3'd2, 8'b0000_0100, 1'b0);

    // Plain miss
    srch_tag = 10'h123;
    tick();
    chk_res("miss", 1'b1, 1'b0, '0, '0, 1'b0);

    // Fill all entries; overwrites of valid entries keep occupancy
    idle();
    for (int unsigned i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_idx = IDX_W'(i); wr_tag = TAG_W'(10'h100 + i);
      tick();
      chk($sformatf("fill%0d.occ", i), 32'(occupancy), exp_occ[i]);
    end
    idle(); srch_en = 1'b1; srch_tag = 10'h155;
    tick();
    chk_res("ovw.old", 1'b1, 1'b0, '0, '0, 1'b0);
    srch_tag = 10'h105;
    tick();
    chk_res("ovw.new", 1'b1, 1'b1, 3'd5, 8'b0010_0000, 1'b0);

    // Flush beats a same-cycle write
    idle(); flush = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_tag = 10'h3C3;
    tick();
    chk("flush.occ", 32'(occupancy), 32'd0);
    idle(); srch_en = 1'b1; srch_tag = 10'h3C3;
    tick();
    chk_res("flush.s0", 1'b1, 1'b0, '0, '0, 1'b0);
    srch_tag = 10'h100;
    tick();
    chk_res("flush.s1", 1'b1, 1'b0, '0, '0, 1'b0);

    // Write wins over invalidate on the same index
    idle(); wr_en = 1'b1; inv_en = 1'b1; wr_idx = 3'd4; inv_idx = 3'd4; wr_tag = 10'h3FF;
    tick();
    chk("wi.occ", 32'(occupancy), 32'd1);
    idle(); srch_en = 1'b1; srch_tag = 10'h3FF;
    tick();
    chk_res("wi", 1'b1, 1'b1, 3'd4, 8'b0001_0000, 1'b0);
    idle(); inv_en = 1'b1; inv_idx = 3'd4;
    tick();
    chk("inv.occ", 32'(occupancy), 32'd0);
    idle(); srch_en = 1'b1;
    tick();
    chk_res("inv", 1'b1, 1'b0, '0, '0, 1'b0);

    // Invalidate of an invalid entry is a no-op
    idle(); wr_en = 1'b1; wr_idx = 3'd6; wr_tag = 10'h011;
    tick();
    idle(); inv_en = 1'b1; inv_idx = 3'd4;
    tick();
    chk("inv2.occ", 32'(occupancy), 32'd1);

    // Asynchronous reset during a search
    idle(); wr_en = 1'b1; wr_idx = 3'd7; wr_tag = 10'h2A5;
    tick();
    idle(); srch_en = 1'b1; srch_tag = 10'h2A5;
    tick();
    chk_res("prerst", 1'b1, 1'b1, 3'd7, 8'b1000_0000, 1'b0);
    chk("prerst.occ", 32'(occupancy), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_res("midrst", 1'b0, 1'b0, '0, '0, 1'b0);
    chk("midrst.occ", 32'(occupancy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_res("postrst", 1'b1, 1'b0, '0, '0, 1'b0);

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
